// File: rtl/stats_uart_tx_if.sv
// Handshake bundle between the telemetry source (master) and the UART frame
// transmitter (slave): stat snapshot inputs, frame request and serial/status outputs.
interface stats_uart_tx_if;
  logic       start;
  logic [3:0] hunger;
  logic [3:0] happiness;
  logic [3:0] health;
  logic [3:0] hygiene;
  logic [3:0] energy;
  logic [3:0] social;
  logic [6:0] status;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    output start, hunger, happiness, health, hygiene, energy, social, status,
    input  tx, busy, frame_done
  );

  modport slave (
    input  start, hunger, happiness, health, hygiene, energy, social, status,
    output tx, busy, frame_done
  );
endinterface

// File: rtl/stats_uart_tx.sv
// Telemetry UART transmitter: snapshots pet stats on request and sends a fixed
// 6-byte 8N1 frame (header, four packed stat bytes, XOR checksum) on tx.
module stats_uart_tx #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd1042,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input logic           clk,
  input logic           rst_n,
  stats_uart_tx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t      state;
  logic [15:0] baud;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic [30:0] snap;
  logic        tx_r;
  logic        busy_r;
  logic        done_r;
  logic [7:0]  cur_byte;
  logic [2:0]  next_bit;
  logic        bit_end;

  // Snapshot layout: {hunger, happiness, health, hygiene, energy, social, status}
  function automatic logic [7:0] frame_byte(input logic [30:0] s,
                                            input logic [2:0]  idx,
                                            input logic [7:0]  hdr);
    logic [7:0] b1, b2, b3, b4;
    b1 = s[30:23];
    b2 = s[22:15];
    b3 = s[14:7];
    b4 = {1'b0, s[6:0]};
    case (idx)
      3'd0:    frame_byte = hdr;
      3'd1:    frame_byte = b1;
      3'd2:    frame_byte = b2;
      3'd3:    frame_byte = b3;
      3'd4:    frame_byte = b4;
      3'd5:    frame_byte = b1 ^ b2 ^ b3 ^ b4;
      default: frame_byte = hdr;
    endcase
  endfunction

  assign cur_byte = frame_byte(snap, byte_idx, HEADER);
  assign next_bit = bit_idx + 3'd1;
  assign bit_end  = (baud == CLKS_PER_BIT - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      snap     <= '0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state)
        // DONE behaves like IDLE for acceptance, so a start held through the
        // done pulse launches the next frame without an extra idle cycle.
        IDLE, DONE: begin
          state  <= IDLE;
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (bus.start) begin
            snap     <= {bus.hunger, bus.happiness, bus.health, bus.hygiene,
                         bus.energy, bus.social, bus.status};
            state    <= START;
            tx_r     <= 1'b0;
            busy_r   <= 1'b1;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            tx_r    <= cur_byte[0];
            state   <= DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx_r  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= next_bit;
              tx_r    <= cur_byte[next_bit];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (byte_idx == 3'd5) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              tx_r     <= 1'b0;
              state    <= START;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx         = tx_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = done_r;

endmodule

// File: tb/tb_stats_uart_tx.sv
// Directed bench for stats_uart_tx at 4 clocks per bit: decodes each frame
// cycle by cycle and compares against hand-computed byte sequences.
module tb_stats_uart_tx;

  localparam int CPB  = 4;
  localparam int FLEN = 60 * CPB;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic tx_s   [0:FLEN];
  logic busy_s [0:FLEN];
  logic fd_s   [0:FLEN];

  stats_uart_tx_if bus ();

  stats_uart_tx #(
    .CLKS_PER_BIT(16'd4),
    .HEADER      (8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_stats(input logic [3:0] hu, input logic [3:0] ha, input logic [3:0] he,
                           input logic [3:0] hy, input logic [3:0] en, input logic [3:0] so,
                           input logic [6:0] st);
    bus.hunger    = hu;
    bus.happiness = ha;
    bus.health    = he;
    bus.hygiene   = hy;
    bus.energy    = en;
    bus.social    = so;
    bus.status    = st;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered at a negedge; index 0 is the first cycle with tx low.
  task automatic capture_frame();
    int w;
    w = 0;
    while (bus.tx !== 1'b0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) check("frame_start_timeout", 64'd1, 64'd0);
    for (int i = 0; i <= FLEN; i++) begin
      if (i > 0) @(negedge clk);
      tx_s[i]   = bus.tx;
      busy_s[i] = bus.busy;
      fd_s[i]   = bus.frame_done;
    end
  endtask

  task automatic check_frame(input string tag, input logic [47:0] exp);
    logic [47:0] got;
    logic        v;
    int          width_err, frame_err, busy_cnt, fd_early;
    got = '0;
    width_err = 0; frame_err = 0; busy_cnt = 0; fd_early = 0;
    for (int n = 0; n < 60; n++) begin
      v = tx_s[n*CPB + 1];
      for (int c = 0; c < CPB; c++)
        if (tx_s[n*CPB + c] !== v) width_err++;
      if (n % 10 == 0) begin
        if (v !== 1'b0) frame_err++;
      end else if (n % 10 == 9) begin
        if (v !== 1'b1) frame_err++;
      end else begin
        got[47 - 8*(n/10) - 7 + (n%10 - 1)] = v;
      end
    end
    for (int i = 0; i < FLEN; i++) begin
      if (busy_s[i] === 1'b1) busy_cnt++;
      if (fd_s[i] !== 1'b0) fd_early++;
    end
    check({tag, "_bytes"},     {16'd0, got}, {16'd0, exp});
    check({tag, "_framing"},   64'(frame_err), 64'd0);
    check({tag, "_bitwidth"},  64'(width_err), 64'd0);
    check({tag, "_busy_len"},  64'(busy_cnt), 64'(FLEN));
    check({tag, "_fd_early"},  64'(fd_early), 64'd0);
    check({tag, "_fd_at_end"}, {63'd0, fd_s[FLEN]}, 64'd1);
    check({tag, "_busy_end"},  {63'd0, busy_s[FLEN]}, 64'd0);
    check({tag, "_tx_end"},    {63'd0, tx_s[FLEN]}, 64'd1);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b1;
    set_stats(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 7'h00);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_tx",   {63'd0, bus.tx},         64'd1);
      check("rst_busy", {63'd0, bus.busy},       64'd0);
      check("rst_fd",   {63'd0, bus.frame_done}, 64'd0);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    check_quiet("idle_after_reset", 100);

    // Basic frame
    set_stats(4'h3, 4'h7, 4'hF, 4'h0, 4'hA, 4'h5, 7'h55);
    pulse_start();
    check("tx_fall", {63'd0, bus.tx},   64'd0);
    check("busy_on", {63'd0, bus.busy}, 64'd1);
    capture_frame();
    check_frame("frame1", 48'hA5_37_F0_A5_55_37);

    // Snapshot held; start during frame ignored
    set_stats(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 7'h12);
    pulse_start();
    fork
      capture_frame();
      begin
        repeat (50) @(negedge clk);
        set_stats(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 7'h00);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    check_frame("snapshot", 48'hA5_12_34_56_12_62);
    check_quiet("no_second_frame", 100);

    // Back-to-back with start held; first frame is the checksum edge case
    set_stats(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 7'h7F);
    @(negedge clk);
    bus.start = 1'b1;
    fork
      capture_frame();
      begin
        repeat (20) @(negedge clk);
        set_stats(4'h3, 4'h7, 4'hF, 4'h0, 4'hA, 4'h5, 7'h55);
      end
    join
    check_frame("cksum_edge", 48'hA5_FF_FF_FF_7F_80);
    @(negedge clk);
    check("b2b_start_bit", {63'd0, bus.tx},   64'd0);
    check("b2b_busy",      {63'd0, bus.busy}, 64'd1);
    bus.start = 1'b0;
    capture_frame();
    check_frame("b2b_frame2", 48'hA5_37_F0_A5_55_37);

    // Reset during byte B2 (cycles 80..119 of the frame)
    set_stats(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 7'h12);
    pulse_start();
    repeat (90) @(negedge clk);
    check("midframe_busy", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_tx",   {63'd0, bus.tx},         64'd1);
    check("abort_busy", {63'd0, bus.busy},       64'd0);
    check("abort_fd",   {63'd0, bus.frame_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    set_stats(4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'h1, 7'h3C);
    pulse_start();
    capture_frame();
    check_frame("after_abort", 48'hA5_89_CD_E1_3C_99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
